// File: rtl/cpu_pkg.sv
// Shared encodings for the data-memory port arbiter: access owner, arbiter state
// and the default CPU word width.
package cpu_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_UART = 2'd2
    } ownerT;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ULOCK = 1'b1
    } arbStateT;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the CPU memory stage, the UART loader and the
// data RAM; the arbiter takes the slave view, requesters and RAM the master view.
interface mem_port_arbiter_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
);

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              uart_req;
    logic              uart_lock;
    logic              uart_we;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic              uart_gnt;
    logic [DATA_W-1:0] uart_rdata;
    logic              uart_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  uart_req, uart_lock, uart_we, uart_addr, uart_wdata,
        output uart_gnt, uart_rdata, uart_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output uart_req, uart_lock, uart_we, uart_addr, uart_wdata,
        input  uart_gnt, uart_rdata, uart_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_age_counter.sv
// Counts cycles a UART request has been refused; raises uartForce once the
// refusal count reaches MAX_WAIT so the CPU cannot starve the loader.
module arb_age_counter
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic uartReq,
    input  logic uartGnt,
    output logic uartForce
);

    localparam logic [3:0] THRESH = 4'(MAX_WAIT);

    logic [3:0] waitCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (uartGnt || !uartReq) begin
            waitCnt <= '0;
        end else if (waitCnt != 4'hF) begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    assign uartForce = uartReq && (waitCnt >= THRESH);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared by the CPU memory stage and the UART loader.
// Optional build macro ARB_PERF_CNT_EN adds conflict / CPU-stall counters.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     bus
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic                  perf_clr,
    output logic [15:0]           conflict_cnt,
    output logic [15:0]           cpu_stall_cnt
`endif
);

    arbStateT          state;
    ownerT             rdOwner;
    logic              uartForce;
    logic              lockHeld;
    logic              cpuGnt;
    logic              uartGnt;
    logic [ADDR_W-1:0] muxAddr;
    logic [DATA_W-1:0] muxWdata;
    logic              muxWe;

    arb_age_counter #(.MAX_WAIT(MAX_WAIT)) ageCounter (
        .clk       (clk),
        .reset     (reset),
        .uartReq   (bus.uart_req),
        .uartGnt   (uartGnt),
        .uartForce (uartForce)
    );

    // Lock only holds while both request and lock stay high; otherwise this
    // cycle already falls back to normal arbitration.
    always_comb begin
        cpuGnt   = 1'b0;
        uartGnt  = 1'b0;
        lockHeld = (state == ST_ULOCK) && bus.uart_req && bus.uart_lock;
        if (reset) begin
            if (lockHeld || uartForce) begin
                uartGnt = 1'b1;
            end else if (bus.cpu_req) begin
                cpuGnt = 1'b1;
            end else if (bus.uart_req) begin
                uartGnt = 1'b1;
            end
        end
    end

    always_comb begin
        muxAddr  = '0;
        muxWdata = '0;
        muxWe    = 1'b0;
        if (cpuGnt) begin
            muxAddr  = bus.cpu_addr;
            muxWdata = bus.cpu_wdata;
            muxWe    = bus.cpu_we;
        end else if (uartGnt) begin
            muxAddr  = bus.uart_addr;
            muxWdata = bus.uart_wdata;
            muxWe    = bus.uart_we;
        end
    end

    assign bus.mem_en    = cpuGnt || uartGnt;
    assign bus.mem_we    = muxWe;
    assign bus.mem_addr  = muxAddr;
    assign bus.mem_wdata = muxWdata;

    assign bus.uart_gnt  = uartGnt;
    assign bus.cpu_stall = bus.cpu_req && !cpuGnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_ARB;
            rdOwner <= OWN_NONE;
        end else begin
            state <= (uartGnt && bus.uart_lock) ? ST_ULOCK : ST_ARB;
            if (cpuGnt && !bus.cpu_we) begin
                rdOwner <= OWN_CPU;
            end else if (uartGnt && !bus.uart_we) begin
                rdOwner <= OWN_UART;
            end else begin
                rdOwner <= OWN_NONE;
            end
        end
    end

    // Synchronous RAM data lands one cycle after the grant; steer it by owner.
    assign bus.cpu_rvalid  = (rdOwner == OWN_CPU);
    assign bus.uart_rvalid = (rdOwner == OWN_UART);
    assign bus.cpu_rdata   = (rdOwner == OWN_CPU)  ? bus.mem_rdata : '0;
    assign bus.uart_rdata  = (rdOwner == OWN_UART) ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt  <= '0;
            cpu_stall_cnt <= '0;
        end else if (perf_clr) begin
            conflict_cnt  <= '0;
            cpu_stall_cnt <= '0;
        end else begin
            if (bus.cpu_req && bus.uart_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (bus.cpu_stall && (cpu_stall_cnt != 16'hFFFF)) begin
                cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: synchronous RAM model plus read-return scoreboard.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic        perfClr = 1'b0;
    logic [15:0] conflictCnt;
    logic [15:0] stallCnt;
`endif

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_clr      (perfClr),
        .conflict_cnt  (conflictCnt),
        .cpu_stall_cnt (stallCnt)
`endif
    );

    function automatic logic [15:0] initVal(input int unsigned i);
        return (i == 32'h10) ? 16'hBEEF : 16'(i * 37 + 32'h1000);
    endfunction

    // Synchronous RAM environment
    logic [15:0] ram [256];
    logic [15:0] ramQ = '0;
    bit          ramLoaded = 1'b0;
    always @(posedge clk) begin
        if (!ramLoaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= initVal(i);
            ramLoaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ramQ <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ramQ;

    logic [15:0] refMem [256];

    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } rdExpT;
    rdExpT cpuQ[$];
    rdExpT uartQ[$];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit monEn  = 1'b0;

    // Read-return scoreboard: every cycle either the front entry is due or the port is idle.
    always @(negedge clk) begin
        if (monEn && rst_n) begin
            checks++;
            if (cpuQ.size() > 0 && cpuQ[0].due == cyc) begin
                if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== cpuQ[0].data) begin
                    errors++;
                    $display("FAIL cpu_return cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                             cyc, bus.cpu_rvalid, bus.cpu_rdata, cpuQ[0].data);
                end
                void'(cpuQ.pop_front());
            end else if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 16'h0) begin
                errors++;
                $display("FAIL cpu_idle cyc=%0d got rvalid=%b rdata=%h expected rvalid=0 rdata=0000",
                         cyc, bus.cpu_rvalid, bus.cpu_rdata);
            end
            checks++;
            if (uartQ.size() > 0 && uartQ[0].due == cyc) begin
                if (bus.uart_rvalid !== 1'b1 || bus.uart_rdata !== uartQ[0].data) begin
                    errors++;
                    $display("FAIL uart_return cyc=%0d got rvalid=%b rdata=%h expected rvalid=1 rdata=%h",
                             cyc, bus.uart_rvalid, bus.uart_rdata, uartQ[0].data);
                end
                void'(uartQ.pop_front());
            end else if (bus.uart_rvalid !== 1'b0 || bus.uart_rdata !== 16'h0) begin
                errors++;
                $display("FAIL uart_idle cyc=%0d got rvalid=%b rdata=%h expected rvalid=0 rdata=0000",
                         cyc, bus.uart_rvalid, bus.uart_rdata);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.uart_req   = 1'b0;
        bus.uart_lock  = 1'b0;
        bus.uart_we    = 1'b0;
        bus.uart_addr  = '0;
        bus.uart_wdata = '0;
    endtask

    task automatic test_reset;
        idleAll();
        for (int i = 0; i < 256; i++) refMem[i] = initVal(i);
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.uart_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.uart_rvalid, bus.cpu_stall} !== 6'b0
            || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_idle got gnt/en/we/crv/urv/stall=%b%b%b%b%b%b addr=%h expected all 0",
                     bus.uart_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.uart_rvalid,
                     bus.cpu_stall, bus.mem_addr);
        end
        bus.cpu_req  = 1'b1;
        bus.uart_req = 1'b1;
        #1;
        checks++;
        if ({bus.uart_gnt, bus.mem_en} !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_blocked got uart_gnt=%b mem_en=%b expected 0 0", bus.uart_gnt, bus.mem_en);
        end
        idleAll();
`ifdef ARB_PERF_CNT_EN
        checks++;
        if (conflictCnt !== 16'h0 || stallCnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_perf got conflict=%0d stall=%0d expected 0 0", conflictCnt, stallCnt);
        end
`endif
        #2 rst_n = 1'b1;
        monEn = 1'b1;
        tick();
    endtask

    task automatic test_cpu_only;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h10;
        @(negedge clk);
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.cpu_stall, bus.uart_gnt} !== 4'b1000 || bus.mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL cpu_only_grant got en/we/stall/ugnt=%b%b%b%b addr=%h expected 1000 addr=10",
                     bus.mem_en, bus.mem_we, bus.cpu_stall, bus.uart_gnt, bus.mem_addr);
        end
        cpuQ.push_back('{due: cyc + 1, data: 16'hBEEF});
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL cpu_only_stall got %b expected 0", bus.cpu_stall);
        end
        tick();
    endtask

    task automatic test_contention;
        logic       exp;
        logic [7:0] expAddr;
`ifdef ARB_PERF_CNT_EN
        perfClr = 1'b1;
        tick();
        perfClr = 1'b0;
`endif
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 8'h05;
        bus.uart_req   = 1'b1;
        bus.uart_we    = 1'b1;
        bus.uart_addr  = 8'h20;
        bus.uart_wdata = 16'h1234;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp     = (c == 4);
            expAddr = exp ? 8'h20 : 8'h05;
            checks++;
            if ({bus.uart_gnt, bus.cpu_stall, bus.mem_we} !== {exp, exp, exp} || bus.mem_addr !== expAddr) begin
                errors++;
                $display("FAIL contention_c%0d got ugnt/stall/we=%b%b%b addr=%h expected %b%b%b addr=%h",
                         c, bus.uart_gnt, bus.cpu_stall, bus.mem_we, bus.mem_addr, exp, exp, exp, expAddr);
            end
            if (exp) refMem[8'h20] = 16'h1234;
            else     cpuQ.push_back('{due: cyc + 1, data: refMem[8'h05]});
            tick();
        end
        idleAll();
`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        checks++;
        if (conflictCnt !== 16'd6 || stallCnt !== 16'd1) begin
            errors++;
            $display("FAIL perf_counts got conflict=%0d stall=%0d expected 6 1", conflictCnt, stallCnt);
        end
        tick();
        perfClr = 1'b1;
        tick();
        perfClr = 1'b0;
        @(negedge clk);
        checks++;
        if (conflictCnt !== 16'd0 || stallCnt !== 16'd0) begin
            errors++;
            $display("FAIL perf_clr got conflict=%0d stall=%0d expected 0 0", conflictCnt, stallCnt);
        end
`endif
        tick();
    endtask

    task automatic test_lock_burst;
        logic        exp;
        logic [7:0]  k;
        logic [7:0]  expAddr;
        logic [15:0] expData;
        k = 8'd0;
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b1;
        bus.cpu_addr   = 8'h30;
        bus.cpu_wdata  = 16'hC0DE;
        bus.uart_req   = 1'b1;
        bus.uart_lock  = 1'b1;
        bus.uart_we    = 1'b1;
        bus.uart_addr  = 8'h00;
        bus.uart_wdata = 16'h0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp     = (c >= 4);
            expAddr = exp ? k : 8'h30;
            expData = exp ? 16'(k + 8'd1) : 16'hC0DE;
            checks++;
            if ({bus.uart_gnt, bus.cpu_stall} !== {exp, exp} || bus.mem_addr !== expAddr
                || bus.mem_wdata !== expData) begin
                errors++;
                $display("FAIL lock_c%0d got ugnt/stall=%b%b addr=%h wdata=%h expected %b%b addr=%h wdata=%h",
                         c, bus.uart_gnt, bus.cpu_stall, bus.mem_addr, bus.mem_wdata, exp, exp, expAddr, expData);
            end
            if (exp) begin
                refMem[k] = 16'(k + 8'd1);
                k = k + 8'd1;
            end else begin
                refMem[8'h30] = 16'hC0DE;
            end
            tick();
            if (exp && k < 8'd4) begin
                bus.uart_addr  = k;
                bus.uart_wdata = 16'(k + 8'd1);
            end
        end
        bus.uart_lock = 1'b0;
        bus.uart_we   = 1'b0;
        bus.uart_addr = 8'h01;
        @(negedge clk);
        checks++;
        if ({bus.uart_gnt, bus.cpu_stall} !== 2'b00 || bus.mem_addr !== 8'h30) begin
            errors++;
            $display("FAIL lock_exit got ugnt/stall=%b%b addr=%h expected 00 addr=30",
                     bus.uart_gnt, bus.cpu_stall, bus.mem_addr);
        end
        tick();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.uart_gnt !== 1'b1 || bus.mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL lock_after_read got ugnt=%b addr=%h expected 1 addr=01", bus.uart_gnt, bus.mem_addr);
        end
        uartQ.push_back('{due: cyc + 1, data: refMem[8'h01]});
        tick();
        idleAll();
        tick();
    endtask

    task automatic test_interleaved_reads;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h02;
        @(negedge clk);
        checks++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL inter_cpu got stall=%b addr=%h expected 0 addr=02", bus.cpu_stall, bus.mem_addr);
        end
        cpuQ.push_back('{due: cyc + 1, data: refMem[8'h02]});
        tick();
        bus.cpu_req   = 1'b0;
        bus.uart_req  = 1'b1;
        bus.uart_we   = 1'b0;
        bus.uart_addr = 8'h03;
        @(negedge clk);
        checks++;
        if (bus.uart_gnt !== 1'b1 || bus.mem_addr !== 8'h03) begin
            errors++;
            $display("FAIL inter_uart got ugnt=%b addr=%h expected 1 addr=03", bus.uart_gnt, bus.mem_addr);
        end
        uartQ.push_back('{due: cyc + 1, data: refMem[8'h03]});
        tick();
        bus.uart_addr = 8'h20;
        @(negedge clk);
        checks++;
        if (bus.uart_gnt !== 1'b1 || bus.mem_addr !== 8'h20) begin
            errors++;
            $display("FAIL inter_uart2 got ugnt=%b addr=%h expected 1 addr=20", bus.uart_gnt, bus.mem_addr);
        end
        uartQ.push_back('{due: cyc + 1, data: refMem[8'h20]});
        tick();
        idleAll();
        tick();
    endtask

    task automatic test_reset_mid_lock;
        logic exp;
        monEn = 1'b0;
        bus.uart_req  = 1'b1;
        bus.uart_lock = 1'b1;
        bus.uart_we   = 1'b0;
        bus.uart_addr = 8'h01;
        @(negedge clk);
        checks++;
        if (bus.uart_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rml_enter got ugnt=%b expected 1", bus.uart_gnt);
        end
        tick();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'h05;
        bus.uart_addr = 8'h02;
        @(negedge clk);
        checks++;
        if ({bus.uart_gnt, bus.cpu_stall, bus.uart_rvalid} !== 3'b111 || bus.uart_rdata !== refMem[8'h01]) begin
            errors++;
            $display("FAIL rml_locked got ugnt/stall/urv=%b%b%b rdata=%h expected 111 rdata=%h",
                     bus.uart_gnt, bus.cpu_stall, bus.uart_rvalid, bus.uart_rdata, refMem[8'h01]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.uart_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.uart_rvalid} !== 5'b0
            || bus.uart_rdata !== 16'h0) begin
            errors++;
            $display("FAIL rml_async got ugnt/en/we/crv/urv=%b%b%b%b%b urdata=%h expected 00000 0000",
                     bus.uart_gnt, bus.mem_en, bus.mem_we, bus.cpu_rvalid, bus.uart_rvalid, bus.uart_rdata);
        end
        idleAll();
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        monEn = 1'b1;
        tick();
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 8'h05;
        bus.uart_req   = 1'b1;
        bus.uart_we    = 1'b1;
        bus.uart_addr  = 8'h40;
        bus.uart_wdata = 16'hAAAA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = (c == 4);
            checks++;
            if ({bus.uart_gnt, bus.cpu_stall} !== {exp, exp}) begin
                errors++;
                $display("FAIL rml_rearb_c%0d got ugnt/stall=%b%b expected %b%b",
                         c, bus.uart_gnt, bus.cpu_stall, exp, exp);
            end
            if (exp) refMem[8'h40] = 16'hAAAA;
            else     cpuQ.push_back('{due: cyc + 1, data: refMem[8'h05]});
            tick();
        end
        idleAll();
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cpu_only();
        test_contention();
        test_lock_burst();
        test_interleaved_reads();
        test_reset_mid_lock();
        @(negedge clk);
        checks++;
        if (cpuQ.size() != 0 || uartQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got cpu=%0d uart=%0d pending expected 0 0", cpuQ.size(), uartQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single data-memory port between the CPU pipeline's memory stage and the UART loader/debug requester. CPU has priority. An aging counter guarantees UART service, and a lock mode lets UART stream program/data words back-to-back. Drives the memory-stage stall when the CPU loses arbitration, and routes synchronous-RAM read data back to the owner of each access.

Parameters:
ADDR_W, 8, memory word-address width
DATA_W, 16, data width (matches CPU word)
MAX_WAIT, 4, cycles a pending UART request may be refused before it is forced to win (1..15)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU memory-stage access request
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_stall  out  1  cpu_req & ~cpu_gnt; holds the pipeline
cpu_rdata  out  DATA_W  read data to CPU
cpu_rvalid  out  1  cpu_rdata valid (1 cycle after granted read)
uart_req  in  1  UART access request
uart_lock  in  1  keep UART ownership while high
uart_we  in  1  1=write, 0=read
uart_addr  in  ADDR_W  UART address
uart_wdata  in  DATA_W  UART write data
uart_gnt  out  1  UART access accepted this cycle
uart_rdata  out  DATA_W  read data to UART
uart_rvalid  out  1  uart_rdata valid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous RAM read data, valid 1 cycle after mem_en & ~mem_we

Behaviour:
- One access per cycle; grant is combinational from state + requests; mem_* are a mux of the winner; no winner -> mem_en=mem_we=0, addr/wdata=0.
- While reset low: all grants, mem_en, mem_we, rvalids = 0; state=ARB; wait_cnt=0; rd_owner=NONE.
- States: ARB, ULOCK.
- ARB: uart_force = uart_req & (wait_cnt >= MAX_WAIT).
  - uart_force -> UART wins.
  - else cpu_req -> CPU wins.
  - else uart_req -> UART wins.
- ARB -> ULOCK when UART wins and uart_lock=1.
- ULOCK: UART wins every cycle uart_req=1; CPU stalls. Exit to ARB on uart_lock=0 or uart_req=0, evaluated the same cycle, so arbitration in that cycle uses ARB rules.
- wait_cnt (4 bit, saturating at 15):
  - reset to 0 when uart_gnt or ~uart_req;
  - otherwise +1 each cycle.
- cpu_gnt is internal; cpu_stall = cpu_req & ~cpu_gnt. A stalled CPU holds its request; no request is dropped.
- Read return: on a granted read, rd_owner <= winner; else NONE. Next cycle: owner's rvalid=1 and rdata=mem_rdata, other rvalid=0. rdata ports are 0 when not valid.
- Writes: no response; the granted cycle is the completion.
- Simultaneous cpu_req & uart_req with wait_cnt<MAX_WAIT: CPU wins; UART waits at most MAX_WAIT cycles.
- Reset asserted mid-lock or mid-read: the pending rvalid is discarded; the pipeline/loader re-issue.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds outputs conflict_cnt[15:0] (cycles with cpu_req & uart_req) and cpu_stall_cnt[15:0] (cycles cpu_stall=1). Both saturate at 16'hFFFF, are cleared by reset, and are cleared by a new input perf_clr (synchronous, 1 cycle).
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg): owner encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_UART=2'd2; state encoding ST_ARB=1'b0, ST_ULOCK=1'b1; DATA_W default 16.
- One sub-module: arb_age_counter (saturating wait counter with clear and threshold compare, outputs uart_force).

Test Plan:
- CPU only: cpu_req=1, we=0, addr=8'h10, RAM[10]=16'hBEEF -> mem_en=1 same cycle; cpu_rvalid=1, cpu_rdata=16'hBEEF next cycle; cpu_stall=0 throughout.
- Contention, MAX_WAIT=4: cpu_req and uart_req held high from cycle 0 -> CPU granted cycles 0-3, uart_gnt=1 and cpu_stall=1 at cycle 4, CPU granted again at cycle 5.
- Lock burst: UART writes 16'h0001..16'h0004 to addr 0..3 with uart_lock=1 while cpu_req=1 -> four consecutive uart_gnt, cpu_stall=1 for 4 cycles; CPU granted the cycle after uart_lock drops.
- Interleaved reads: CPU read addr 2 in cycle n, UART read addr 3 in cycle n+1 -> cpu_rvalid only at n+1 with RAM[2]; uart_rvalid only at n+2 with RAM[3].
- Async reset mid-lock: reset low between clocks during ULOCK with a read in flight -> grants, mem_en, rvalids go 0 immediately; after release state=ARB, wait_cnt=0, no spurious rvalid.
- ARB_PERF_CNT_EN: 6 contended cycles -> conflict_cnt=6, cpu_stall_cnt=1 (MAX_WAIT=4); perf_clr pulse -> both 0.
